bvh_unit: RTL and testbench

Fixed-point BVH traversal engine for the ray-tracing shadow stage. On a start strobe it walks a binary BVH from root node 0 using an explicit stack, slab-testing both child boxes of each node against the ray. It reports every intersected leaf as a primitive range (`start`, `count`) to the caller's primitive FIFO. An external combinational any-hit unit then tests those primitives.

---
 rtl/bvh_unit.sv | 150 +++++++++++++++
 tb/tb_bvh_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bvh_unit.sv
// Fixed-point BVH traversal engine: one node per cycle, both children slab-tested,
// leaf hits reported as primitive ranges. Packed port layouts:
//   r[0]=Orig[3], r[1]=InvDir[3]; node[c]={IsLeaf, Child, Max[2:0], Min[2:0]}; leaf[c]={NumPrim, StartPrim}.
module bvh_unit #(
   parameter int NODE_INDEX_WIDTH  = 8,
   parameter int PRIM_INDEX_WIDTH  = 8,
   parameter int PRIM_AMOUNT_WIDTH = 4,
   parameter int COORD_WIDTH       = 32,
   parameter int STACK_DEPTH       = 16
) (
   input  logic                                                 clk,
   input  logic                                                 resetn,
   input  logic                                                 strobe,
   input  logic                                                 restart_strobe,
   input  logic [2:0][COORD_WIDTH-1:0]                          offset,
   input  logic [1:0][2:0][COORD_WIDTH-1:0]                     r,
   output logic [NODE_INDEX_WIDTH-1:0]                          node_index,
   input  logic [1:0][6*COORD_WIDTH+NODE_INDEX_WIDTH:0]         node,
   input  logic [1:0][PRIM_AMOUNT_WIDTH+PRIM_INDEX_WIDTH-1:0]   leaf,
   output logic [1:0][PRIM_INDEX_WIDTH-1:0]                     start_prim,
   output logic [1:0][PRIM_AMOUNT_WIDTH-1:0]                    num_prim,
   output logic                                                 valid,
   output logic                                                 finished
);

   localparam int CW    = COORD_WIDTH;
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int SPI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_TRAVERSE = 2'd1;
   localparam logic [1:0] S_DONE     = 2'd2;

   logic [1:0]                  state;
   logic [SP_W-1:0]             sp;
   logic [NODE_INDEX_WIDTH-1:0] stack [STACK_DEPTH];

   logic signed [CW-1:0]   d_lo   [2][3];
   logic signed [CW-1:0]   d_hi   [2][3];
   logic signed [2*CW-1:0] p_lo   [2][3];
   logic signed [2*CW-1:0] p_hi   [2][3];
   logic signed [CW-1:0]   t_near [2][3];
   logic signed [CW-1:0]   t_far  [2][3];
   logic signed [CW-1:0]   tenter [2];
   logic signed [CW-1:0]   texit  [2];

   logic [1:0]                              hit;
   logic [1:0]                              leaf_hit;
   logic [1:0]                              int_hit;
   logic [1:0][NODE_INDEX_WIDTH-1:0]        child_idx;
   logic [1:0][PRIM_INDEX_WIDTH-1:0]        leaf_start;
   logic [1:0][PRIM_AMOUNT_WIDTH-1:0]       leaf_num;

   always_comb begin
      hit        = '0;
      leaf_hit   = '0;
      int_hit    = '0;
      child_idx  = '0;
      leaf_start = '0;
      leaf_num   = '0;
      for (int unsigned c = 0; c < 2; c++) begin
         for (int unsigned a = 0; a < 3; a++) begin
            d_lo[c][a]   = node[c][a*CW +: CW] + offset[a] - r[0][a];
            d_hi[c][a]   = node[c][(3+a)*CW +: CW] + offset[a] - r[0][a];
            p_lo[c][a]   = d_lo[c][a] * $signed(r[1][a]);
            p_hi[c][a]   = d_hi[c][a] * $signed(r[1][a]);
            // Q16.16 * Q16.16 -> drop 16 fraction bits to return to Q16.16
            t_near[c][a] = p_lo[c][a][CW+15:16];
            t_far[c][a]  = p_hi[c][a][CW+15:16];
            if (t_far[c][a] < t_near[c][a]) begin
               t_near[c][a] = p_hi[c][a][CW+15:16];
               t_far[c][a]  = p_lo[c][a][CW+15:16];
            end
         end
         tenter[c] = t_near[c][0];
         texit[c]  = t_far[c][0];
         for (int unsigned a = 1; a < 3; a++) begin
            if (t_near[c][a] > tenter[c]) tenter[c] = t_near[c][a];
            if (t_far[c][a] < texit[c])   texit[c]  = t_far[c][a];
         end
         hit[c]        = (tenter[c] <= texit[c]) && !texit[c][CW-1];
         child_idx[c]  = node[c][6*CW +: NODE_INDEX_WIDTH];
         leaf_start[c] = leaf[c][PRIM_INDEX_WIDTH-1:0];
         leaf_num[c]   = leaf[c][PRIM_INDEX_WIDTH +: PRIM_AMOUNT_WIDTH];
         leaf_hit[c]   = hit[c] && node[c][6*CW+NODE_INDEX_WIDTH] && (leaf_num[c] != '0);
         int_hit[c]    = hit[c] && !node[c][6*CW+NODE_INDEX_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         node_index <= '0;
         sp         <= '0;
         valid      <= 1'b0;
         finished   <= 1'b0;
         start_prim <= '0;
         num_prim   <= '0;
      end else if (restart_strobe) begin
         state    <= S_IDLE;
         sp       <= '0;
         valid    <= 1'b0;
         finished <= 1'b0;
      end else if (strobe) begin
         state      <= S_TRAVERSE;
         sp         <= '0;
         node_index <= '0;
         valid      <= 1'b0;
         finished   <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            S_TRAVERSE: begin
               if (|leaf_hit) begin
                  valid <= 1'b1;
                  for (int unsigned c = 0; c < 2; c++) begin
                     start_prim[c] <= leaf_hit[c] ? leaf_start[c] : '0;
                     num_prim[c]   <= leaf_hit[c] ? leaf_num[c]   : '0;
                  end
               end
               // A push into a full stack is silently dropped; traversal continues
               if (&int_hit) begin
                  node_index <= child_idx[0];
                  if (sp != SP_FULL) sp <= sp + 1'b1;
               end else if (int_hit[0]) begin
                  node_index <= child_idx[0];
               end else if (int_hit[1]) begin
                  node_index <= child_idx[1];
               end else if (sp != '0) begin
                  node_index <= stack[SPI_W'(sp - 1'b1)];
                  sp         <= sp - 1'b1;
               end else begin
                  state    <= S_DONE;
                  finished <= 1'b1;
               end
            end
            S_IDLE, S_DONE: ;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && !restart_strobe && !strobe && state == S_TRAVERSE
          && (&int_hit) && sp != SP_FULL)
         stack[SPI_W'(sp)] <= child_idx[1];
   end

endmodule

// File: tb/tb_bvh_unit.sv
// Directed bench for bvh_unit: behavioural node/leaf memory, hand-computed expectations.
module tb_bvh_unit;

   localparam int NW = 6*32 + 8 + 1;

   logic                   clk = 1'b0;
   logic                   resetn;
   logic                   strobe;
   logic                   restart_strobe;
   logic [2:0][31:0]       offset;
   logic [1:0][2:0][31:0]  r;
   logic [7:0]             node_index;
   logic [1:0][NW-1:0]     node;
   logic [1:0][11:0]       leaf;
   logic [1:0][7:0]        start_prim;
   logic [1:0][3:0]        num_prim;
   logic                   valid;
   logic                   finished;

   logic [NW-1:0] mem_node [256][2];
   logic [11:0]   mem_leaf [256][2];

   int checks   = 0;
   int failures = 0;

   bvh_unit #(
      .NODE_INDEX_WIDTH(8), .PRIM_INDEX_WIDTH(8), .PRIM_AMOUNT_WIDTH(4),
      .COORD_WIDTH(32), .STACK_DEPTH(16)
   ) dut (
      .clk(clk), .resetn(resetn), .strobe(strobe), .restart_strobe(restart_strobe),
      .offset(offset), .r(r), .node_index(node_index), .node(node), .leaf(leaf),
      .start_prim(start_prim), .num_prim(num_prim), .valid(valid), .finished(finished)
   );

   always #5 clk = ~clk;

   assign node = {mem_node[node_index][1], mem_node[node_index][0]};
   assign leaf = {mem_leaf[node_index][1], mem_leaf[node_index][0]};

   function automatic logic [31:0] q(input int v);
      return 32'(v * 65536);
   endfunction

   function automatic logic [NW-1:0] mk(input logic is_leaf, input logic [7:0] ch,
                                        input int x0, input int x1, input int y0,
                                        input int y1, input int z0, input int z1);
      logic [NW-1:0] v;
      v = '0;
      v[0*32 +: 32] = q(x0); v[1*32 +: 32] = q(y0); v[2*32 +: 32] = q(z0);
      v[3*32 +: 32] = q(x1); v[4*32 +: 32] = q(y1); v[5*32 +: 32] = q(z1);
      v[192 +: 8]   = ch;
      v[200]        = is_leaf;
      return v;
   endfunction

   function automatic logic [NW-1:0] box_hit(input logic is_leaf, input logic [7:0] ch);
      return mk(is_leaf, ch, 1, 2, 1, 2, 1, 2);
   endfunction

   function automatic logic [NW-1:0] box_miss(input logic is_leaf, input logic [7:0] ch);
      return mk(is_leaf, ch, -3, -2, -3, -2, -3, -2);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         for (int c = 0; c < 2; c++) begin
            mem_node[i][c] = box_miss(1'b1, 8'd0);
            mem_leaf[i][c] = '0;
         end
      end
   endtask

   task automatic set_ray(input int ox, input int oy, input int oz,
                          input int ix, input int iy, input int iz);
      r[0][0] = q(ox); r[0][1] = q(oy); r[0][2] = q(oz);
      r[1][0] = q(ix); r[1][1] = q(iy); r[1][2] = q(iz);
   endtask

   task automatic kick();
      strobe = 1'b1;
      step();
      strobe = 1'b0;
   endtask

   // Depth-3 tree: 0 -> {1, 2}; 1 -> {leaf(10,1), 3}; 3 -> {leaf(20,2), miss}; 2 -> {leaf(30,4), leaf(40,1)}
   task automatic load_tree3();
      clear_mem();
      mem_node[0][0] = box_hit(1'b0, 8'd1);
      mem_node[0][1] = box_hit(1'b0, 8'd2);
      mem_node[1][0] = box_hit(1'b1, 8'd0); mem_leaf[1][0] = {4'd1, 8'd10};
      mem_node[1][1] = box_hit(1'b0, 8'd3);
      mem_node[3][0] = box_hit(1'b1, 8'd0); mem_leaf[3][0] = {4'd2, 8'd20};
      mem_node[3][1] = box_miss(1'b1, 8'd0); mem_leaf[3][1] = {4'd1, 8'd99};
      mem_node[2][0] = box_hit(1'b1, 8'd0); mem_leaf[2][0] = {4'd4, 8'd30};
      mem_node[2][1] = box_hit(1'b1, 8'd0); mem_leaf[2][1] = {4'd1, 8'd40};
   endtask

   task automatic test_reset();
      resetn = 1'b0; strobe = 1'b0; restart_strobe = 1'b0; offset = '0;
      set_ray(0, 0, 0, 1, 1, 1);
      clear_mem();
      step(); step();
      checks++; if (node_index !== 8'd0) begin failures++; $display("FAIL reset_node_index got=%0d exp=0", node_index); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (finished !== 1'b0) begin failures++; $display("FAIL reset_finished got=%b exp=0", finished); end
      checks++; if (start_prim !== 16'h0) begin failures++; $display("FAIL reset_start_prim got=%h exp=0", start_prim); end
      checks++; if (num_prim !== 8'h0) begin failures++; $display("FAIL reset_num_prim got=%h exp=0", num_prim); end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_two_leaves();
      clear_mem();
      set_ray(0, 0, 0, 1, 1, 1);
      mem_node[0][0] = box_hit(1'b1, 8'd0); mem_leaf[0][0] = {4'd3, 8'd0};
      mem_node[0][1] = box_hit(1'b1, 8'd0); mem_leaf[0][1] = {4'd2, 8'd5};
      kick();
      checks++; if ({valid, finished} !== 2'b00) begin failures++; $display("FAIL two_leaves_start got=%b exp=00", {valid, finished}); end
      step();
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL two_leaves_valid got=%b exp=1", valid); end
      checks++; if (start_prim !== {8'd5, 8'd0}) begin failures++; $display("FAIL two_leaves_start_prim got=%h exp=0500", start_prim); end
      checks++; if (num_prim !== {4'd2, 4'd3}) begin failures++; $display("FAIL two_leaves_num_prim got=%h exp=23", num_prim); end
      checks++; if (finished !== 1'b1) begin failures++; $display("FAIL two_leaves_finished got=%b exp=1", finished); end
      step();
      checks++; if ({valid, finished, num_prim} !== {2'b01, 4'd2, 4'd3}) begin failures++; $display("FAIL two_leaves_hold got=%h exp=123", {valid, finished, num_prim}); end
      // Re-strobe from DONE
      kick();
      checks++; if (finished !== 1'b0) begin failures++; $display("FAIL b2b_finished_clear got=%b exp=0", finished); end
      step();
      checks++; if ({valid, finished} !== 2'b11) begin failures++; $display("FAIL b2b_second_run got=%b exp=11", {valid, finished}); end
   endtask

   task automatic test_miss();
      clear_mem();
      set_ray(0, 0, -10, 0, 0, 1);
      mem_node[0][0] = mk(1'b1, 8'd0, 5, 6, 5, 6, 5, 6); mem_leaf[0][0] = {4'd1, 8'd1};
      mem_node[0][1] = mk(1'b1, 8'd0, 5, 6, 5, 6, 5, 6); mem_leaf[0][1] = {4'd1, 8'd2};
      kick();
      step();
      checks++; if ({valid, finished} !== 2'b01) begin failures++; $display("FAIL miss_result got=%b exp=01", {valid, finished}); end
   endtask

   task automatic test_depth3();
      load_tree3();
      set_ray(0, 0, 0, 1, 1, 1);
      kick();
      step();
      checks++; if ({valid, finished, node_index} !== {2'b00, 8'd1}) begin failures++; $display("FAIL d3_root got=%h exp=001", {valid, finished, node_index}); end
      step();
      checks++; if ({valid, finished, node_index} !== {2'b10, 8'd3}) begin failures++; $display("FAIL d3_node1 got=%h exp=203", {valid, finished, node_index}); end
      checks++; if ({start_prim[0], num_prim} !== {8'd10, 4'd0, 4'd1}) begin failures++; $display("FAIL d3_node1_slots got=%h exp=0a01", {start_prim[0], num_prim}); end
      step();
      checks++; if ({valid, finished, node_index} !== {2'b10, 8'd2}) begin failures++; $display("FAIL d3_node3_pop got=%h exp=202", {valid, finished, node_index}); end
      checks++; if ({start_prim[0], num_prim} !== {8'd20, 4'd0, 4'd2}) begin failures++; $display("FAIL d3_node3_slots got=%h exp=1402", {start_prim[0], num_prim}); end
      step();
      checks++; if ({valid, finished} !== 2'b11) begin failures++; $display("FAIL d3_node2 got=%b exp=11", {valid, finished}); end
      checks++; if ({start_prim, num_prim} !== {8'd40, 8'd30, 4'd1, 4'd4}) begin failures++; $display("FAIL d3_node2_slots got=%h exp=281e14", {start_prim, num_prim}); end
      step();
      checks++; if ({valid, finished} !== 2'b01) begin failures++; $display("FAIL d3_after got=%b exp=01", {valid, finished}); end
   endtask

   task automatic test_offset();
      clear_mem();
      set_ray(0, 0, 0, 1, 1, 1);
      mem_node[0][0] = mk(1'b1, 8'd0, -11, -10, -1, 1, -1, 1); mem_leaf[0][0] = {4'd3, 8'd7};
      mem_node[0][1] = box_miss(1'b1, 8'd0);                    mem_leaf[0][1] = {4'd1, 8'd99};
      offset = '0;
      kick();
      step();
      checks++; if ({valid, finished} !== 2'b01) begin failures++; $display("FAIL offset_none got=%b exp=01", {valid, finished}); end
      offset[0] = q(10);
      kick();
      step();
      checks++; if ({valid, finished} !== 2'b11) begin failures++; $display("FAIL offset_hit got=%b exp=11", {valid, finished}); end
      checks++; if ({start_prim[0], num_prim} !== {8'd7, 4'd0, 4'd3}) begin failures++; $display("FAIL offset_slots got=%h exp=0703", {start_prim[0], num_prim}); end
      offset = '0;
   endtask

   task automatic test_restart();
      load_tree3();
      set_ray(0, 0, 0, 1, 1, 1);
      kick();
      step();
      restart_strobe = 1'b1; strobe = 1'b1;
      step();
      restart_strobe = 1'b0; strobe = 1'b0;
      checks++; if ({valid, finished} !== 2'b00) begin failures++; $display("FAIL restart_idle got=%b exp=00", {valid, finished}); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({valid, finished} !== 2'b00) begin failures++; $display("FAIL restart_stay_idle got=%b exp=00", {valid, finished}); end
      end
      kick();
      checks++; if ({finished, node_index} !== {1'b0, 8'd0}) begin failures++; $display("FAIL restart_root got=%h exp=000", {finished, node_index}); end
      step();
      checks++; if ({valid, node_index} !== {1'b0, 8'd1}) begin failures++; $display("FAIL restart_descend got=%h exp=001", {valid, node_index}); end
      step();
      checks++; if ({valid, start_prim[0]} !== {1'b1, 8'd10}) begin failures++; $display("FAIL restart_report got=%h exp=10a", {valid, start_prim[0]}); end
   endtask

   task automatic test_reset_mid();
      load_tree3();
      kick();
      step(); step();
      resetn = 1'b0;
      step();
      checks++; if ({node_index, valid, finished, start_prim, num_prim} !== '0) begin
         failures++; $display("FAIL reset_mid_outputs got=%h exp=0", {node_index, valid, finished, start_prim, num_prim});
      end
      resetn = 1'b1;
      step(); step();
      checks++; if ({valid, finished, node_index} !== '0) begin failures++; $display("FAIL reset_mid_idle got=%h exp=0", {valid, finished, node_index}); end
   endtask

   initial begin
      test_reset();
      test_two_leaves();
      test_miss();
      test_depth3();
      test_offset();
      test_restart();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
